// File: rtl/byte_packer_if.sv
// Byte-in / block-out bus for byte_packer: byte stream with abort on one side,
// 128-bit block handshake plus partial-fill count on the other.
interface byte_packer_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [127:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   count;

    modport master (
        output in_byte, in_valid, abort, out_ready,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  in_byte, in_valid, abort, out_ready,
        output in_ready, out, out_valid, count
    );
endinterface

// File: rtl/byte_packer.sv
// Packs 16 consecutive bytes (first byte in the LSBs) into a 128-bit block held
// in a single output register; the assembly register refills while the block waits.
module byte_packer (
    input  logic         clk,
    input  logic         rst,
    byte_packer_if.slave bus
);
    logic [127:0] r_asm;
    logic [127:0] r_out;
    logic [3:0]   r_count;
    logic         r_out_valid;

    logic [127:0] w_asm_next;
    logic         w_in_ready;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_complete;

    // Only the lane addressed by the fill count takes the incoming byte.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign w_asm_next[8*gi +: 8] = (r_count == 4'(gi)) ? bus.in_byte
                                                                : r_asm[8*gi +: 8];
        end
    endgenerate

    // Stall only when the next byte would complete a block and the held block
    // cannot leave this cycle; during reset the port stays open (bytes are dropped).
    assign w_in_ready = !bus.abort &&
                        (rst || !((r_count == 4'hF) && r_out_valid && !bus.out_ready));
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    assign w_complete = w_in_xfer && (r_count == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm       <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (bus.abort) begin
                r_asm   <= '0;
                r_count <= '0;
            end else if (w_in_xfer) begin
                r_asm   <= w_complete ? '0 : w_asm_next;
                r_count <= r_count + 4'd1;
            end

            if (w_complete) begin
                r_out       <= w_asm_next;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_byte_packer.sv
// Directed vector table, hand-written corner sequences, and a random-handshake
// scoreboard run for byte_packer.
module tb_byte_packer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    byte_packer_if bif ();

    byte_packer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       ab;
        logic       ordy;
        logic       exp_rdy;
        logic [3:0] exp_cnt;
        logic       exp_ov;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive at negedge, sample in_ready before the edge, return 1ns after the edge.
    task automatic step(input logic v, input logic [7:0] b, input logic ab,
                        input logic ordy, input logic r, output logic rdy);
        @(negedge clk);
        bif.in_valid  = v;
        bif.in_byte   = b;
        bif.abort     = ab;
        bif.out_ready = ordy;
        rst           = r;
        #1;
        rdy = bif.in_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] blk(input logic [7:0] base);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic do_reset();
        logic rdy;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic send16(input logic [7:0] base, input logic ordy, input string nm);
        logic rdy;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, base + 8'(i), 1'b0, ordy, 1'b0, rdy);
            chk({nm, "_rdy"}, 128'(rdy), 128'(1'b1));
        end
    endtask

    initial begin
        logic         rdy;
        logic [127:0] m_asm;
        logic [127:0] q [$];
        logic [127:0] held;
        logic [127:0] exp_blk;
        logic [7:0]   seq;
        logic         held_vld;
        logic         v;
        logic         ordy;
        logic         m_rdy;
        logic         m_ov;
        int           m_cnt;
        int           blocks_out;
        int           cyc;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_byte = 8'h00;
        bif.abort = 1'b0;
        bif.out_ready = 1'b0;

        // Reset: port stays ready, offered bytes are ignored.
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, rdy);
        chk("rst_in_ready", 128'(rdy), 128'(1'b1));
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, rdy);
        chk("rst_count", 128'(bif.count), 128'(0));
        chk("rst_out_valid", 128'(bif.out_valid), 128'(0));
        chk("rst_out", bif.out, 128'h0);

        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[4] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[6] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].ab, tbl[i].ordy, 1'b0, rdy);
            chk($sformatf("tbl%0d_rdy", i), 128'(rdy), 128'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_cnt", i), 128'(bif.count), 128'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_ov", i), 128'(bif.out_valid), 128'(tbl[i].exp_ov));
        end

        // Back-to-back 0x00..0x0F with out_ready=1: single-cycle out_valid pulse.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, rdy);
            if (i == 14) chk("seq1_ov_early", 128'(bif.out_valid), 128'(0));
        end
        chk("seq1_ov", 128'(bif.out_valid), 128'(1));
        chk("seq1_out", bif.out, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("seq1_cnt", 128'(bif.count), 128'(0));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, rdy);
        chk("seq1_ov_drop", 128'(bif.out_valid), 128'(0));

        // Two blocks with consumer stalled, then simultaneous in/out transfer.
        do_reset();
        send16(8'h10, 1'b0, "seq2_a");
        chk("seq2_ov_a", 128'(bif.out_valid), 128'(1));
        chk("seq2_out_a", bif.out, blk(8'h10));
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, rdy);
            chk("seq2_b_rdy", 128'(rdy), 128'(1));
        end
        chk("seq2_cnt15", 128'(bif.count), 128'(15));
        chk("seq2_hold", bif.out, blk(8'h10));
        step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, rdy);
        chk("seq2_stall_rdy", 128'(rdy), 128'(0));
        chk("seq2_stall_cnt", 128'(bif.count), 128'(15));
        chk("seq2_stall_out", bif.out, blk(8'h10));
        step(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0, rdy);
        chk("seq2_both_rdy", 128'(rdy), 128'(1));
        chk("seq2_both_ov", 128'(bif.out_valid), 128'(1));
        chk("seq2_both_out", bif.out, blk(8'h30));
        chk("seq2_both_cnt", 128'(bif.count), 128'(0));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, rdy);
        chk("seq2_ov_drop", 128'(bif.out_valid), 128'(0));

        // Abort discards a partial block but never the held output.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, rdy);
        chk("seq3_cnt5", 128'(bif.count), 128'(5));
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, rdy);
        chk("seq3_abort_rdy", 128'(rdy), 128'(0));
        chk("seq3_abort_cnt", 128'(bif.count), 128'(0));
        send16(8'hA0, 1'b0, "seq3");
        chk("seq3_ov", 128'(bif.out_valid), 128'(1));
        chk("seq3_out", bif.out, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, rdy);
        chk("seq3_abort_keep_ov", 128'(bif.out_valid), 128'(1));
        chk("seq3_abort_keep_out", bif.out, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, rdy);
        chk("seq3_abort_xfer", 128'(bif.out_valid), 128'(0));

        // Reset mid-operation with a held block and a partial one.
        do_reset();
        send16(8'h40, 1'b0, "seq4_a");
        for (int i = 0; i < 9; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, rdy);
        chk("seq4_cnt9", 128'(bif.count), 128'(9));
        chk("seq4_ov", 128'(bif.out_valid), 128'(1));
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, rdy);
        chk("seq4_rst_rdy", 128'(rdy), 128'(1));
        chk("seq4_rst_ov", 128'(bif.out_valid), 128'(0));
        chk("seq4_rst_out", bif.out, 128'h0);
        chk("seq4_rst_cnt", 128'(bif.count), 128'(0));
        send16(8'h60, 1'b1, "seq4_b");
        chk("seq4_clean_ov", 128'(bif.out_valid), 128'(1));
        chk("seq4_clean_out", bif.out, blk(8'h60));

        // Random handshakes against a reference model and block scoreboard.
        do_reset();
        m_asm = '0;
        m_cnt = 0;
        m_ov = 1'b0;
        held = '0;
        held_vld = 1'b0;
        seq = 8'h00;
        blocks_out = 0;
        cyc = 0;
        while (blocks_out < 1000 && cyc < 60000) begin
            v    = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(1, 0) != 0);
            @(negedge clk);
            bif.in_valid  = v;
            bif.in_byte   = seq ^ 8'h5A;
            bif.abort     = 1'b0;
            bif.out_ready = ordy;
            rst           = 1'b0;
            #1;
            m_rdy = !(m_cnt == 15 && m_ov && !ordy);
            chk("rnd_rdy", 128'(bif.in_ready), 128'(m_rdy));
            chk("rnd_ov", 128'(bif.out_valid), 128'(m_ov));
            if (held_vld && m_ov) chk("rnd_stable", bif.out, held);
            held_vld = 1'b0;
            if (m_ov && ordy) begin
                exp_blk = (q.size() > 0) ? q.pop_front() : 128'hx;
                chk("rnd_block", bif.out, exp_blk);
                blocks_out++;
                m_ov = 1'b0;
            end else if (m_ov) begin
                held = bif.out;
                held_vld = 1'b1;
            end
            if (v && m_rdy) begin
                m_asm[8*m_cnt +: 8] = seq ^ 8'h5A;
                seq++;
                if (m_cnt == 15) begin
                    q.push_back(m_asm);
                    m_asm = '0;
                    m_cnt = 0;
                    m_ov = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            @(posedge clk);
            cyc++;
        end
        if (blocks_out < 1000) begin
            failures++;
            $display("FAIL rnd_timeout blocks=%0d required=1000", blocks_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 The block SHALL have no parameters; the input width is fixed at 8 bits and the output width at 128 bits (16 bytes).
REQ-002 clk  input  1  Rising-edge clock; the only clock.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 in_byte  input  8  Byte offered for packing.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  Block accepts in_byte this cycle.
REQ-007 abort  input  1  Discards the partially assembled block.
REQ-008 out  output  128  Assembled 128-bit block.
REQ-009 out_valid  output  1  out holds a complete, unconsumed block.
REQ-010 out_ready  input  1  Consumer takes out this cycle.
REQ-011 count  output  4  Number of bytes held in the partial assembly, 0..15.

Function
REQ-012 An input transfer SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising clk edge when out_valid=1 and out_ready=1.
REQ-013 The byte accepted with count=k SHALL be written to assembly bits [8k+7:8k]: the first byte goes to [7:0] and the 16th byte goes to [127:120].
REQ-014 Each input transfer SHALL increment count by 1, with 15 wrapping to 0 on the 16th byte.
REQ-015 On the 16th input transfer, the full assembly including that byte SHALL be loaded into out, and out_valid SHALL be 1 on the next cycle (one-cycle latency from the last byte to out_valid).
REQ-016 After the 16th byte, the assembly register SHALL be reusable immediately, so bytes of the next block are accepted while out is still held.
REQ-017 in_ready SHALL be 0 when abort=1.
REQ-018 in_ready SHALL be 0 when count=15, out_valid=1 and out_ready=0 (the output register is full and the next byte would complete a block).
REQ-019 In all other cases in_ready SHALL be 1; in_ready MAY depend combinationally on out_ready and abort.
REQ-020 Simultaneous 16th-byte input transfer and output transfer: out SHALL load the new block, and out_valid SHALL remain 1.
REQ-021 An output transfer without a completing input transfer SHALL clear out_valid on the next cycle.
REQ-022 While out_valid=1 and no output transfer occurs, out SHALL remain stable.
REQ-023 abort=1 SHALL set count to 0 and zero the assembly register on the next edge.
REQ-024 abort SHALL NOT affect out or out_valid, and an output transfer in the same cycle as abort SHALL still complete.
REQ-025 abort with in_valid=1 SHALL discard in_byte (no transfer, because in_ready=0).
REQ-026 Bytes of the assembly register not yet written in the current block SHALL read as zero internally; they are never visible on out.
REQ-027 count SHALL be a registered output reflecting the number of bytes currently held.

Reset
REQ-028 On a rising edge with rst=1, out SHALL be set to 128'h0, out_valid to 0, count to 0, and the assembly register to 0.
REQ-029 rst SHALL take priority over abort and over all transfers.
REQ-030 A partial block in progress at reset SHALL be discarded.
REQ-031 in_ready SHALL read 1 during reset cycles when abort=0; any transfers in those cycles SHALL be ignored.
REQ-032 Reset asserted mid-operation SHALL give the same state as reset from power-up.

Verification
REQ-033 Bytes 0x00..0x0F sent back-to-back with out_ready=1 -> out=128'h0F0E0D0C0B0A09080706050403020100, out_valid high for exactly one cycle, starting one cycle after byte 0x0F is accepted.
REQ-034 Two blocks streamed with out_ready=0 -> the first block is held on out; in_ready drops to 0 when count=15; raising out_ready produces the first block's output transfer and the 16th byte of the second block in the same cycle, and out_valid stays 1 with the second block.
REQ-035 5 bytes sent, then abort pulsed with in_valid=1, then 16 bytes 0xA0..0xAF -> count reads 0 after the abort; out=128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, with none of the 5 earlier bytes in any output.
REQ-036 rst asserted after 9 bytes and with out_valid=1 -> next cycle: out_valid=0, out=0, count=0; the next 16 bytes form a clean block.
REQ-037 Random in_valid and out_ready with a scoreboard over 1000 blocks -> every block is output exactly once and in order, with no loss or duplication, and out is stable while out_valid=1 and out_ready=0.
